// File: rtl/memory_bus_responder_pkg.sv
// Shared bus types for the memory-side responder: packet type encoding,
// packet layout and the fixed address carried by read responses.
package memory_bus_responder_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_ID_W   = 4;

  typedef logic [BUS_ADDR_W-1:0] memory_address_t;
  typedef logic [BUS_DATA_W-1:0] bus_packet_payload_t;
  typedef logic [BUS_ID_W-1:0]   bus_id_t;

  typedef enum logic [1:0] {
    READ_DATA     = 2'd0,
    WRITE_DATA    = 2'd1,
    READ_RESPONSE = 2'd2,
    RESERVED      = 2'd3
  } bus_packet_type_e;

  typedef struct packed {
    bus_packet_type_e    pkt_type;
    bus_id_t             source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } bus_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } responder_state_e;

  localparam memory_address_t RSP_NULL_ADDR = '0;

  function automatic logic is_mem_access(input bus_packet_type_e t);
    return (t == READ_DATA) || (t == WRITE_DATA);
  endfunction

endpackage

// File: rtl/memory_bus_responder_word_array.sv
// Single-port backing store: synchronous write, read data registered on the
// capture edge and held until the next read.
module memory_word_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_index] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_index];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/memory_bus_responder.sv
// Memory target on the bus: takes one request from the request slot, waits a
// fixed latency against a local word array and posts read responses.
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_type,
  input  logic [ID_W-1:0]   req_source,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_payload,
  output logic              req_accept,
  input  logic              rsp_busy,
  output logic              rsp_send,
  output logic [1:0]        rsp_type,
  output logic [ID_W-1:0]   rsp_source,
  output logic [ADDR_W-1:0] rsp_address,
  output logic [DATA_W-1:0] rsp_payload,
  output logic              idle,
  output logic [7:0]        err_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  responder_state_e    r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  bus_packet_type_e    r_type;
  logic [ID_W-1:0]     r_source;
  logic [IDX_W-1:0]    r_index;
  logic [DATA_W-1:0]   r_payload;
  logic                r_req_accept;
  logic [7:0]          r_err_count;
  logic [DATA_W-1:0]   w_rd_data;
  bus_packet_type_e    w_req_type;
  logic                w_capture;
  logic                w_last;

  assign w_req_type = bus_packet_type_e'(req_type);
  // An illegal request returns to IDLE while the slot is still being cleared,
  // so the accept pulse itself blocks a second capture of the same packet.
  assign w_capture  = (r_state == ST_IDLE) && req_valid && !r_req_accept;
  assign w_last     = (r_state == ST_ACCESS) && (r_cnt == '0);

  memory_word_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .i_wr_en  (w_last && (r_type == WRITE_DATA)),
    .i_rd_en  (w_last && (r_type == READ_DATA)),
    .i_index  (r_index),
    .i_wr_data(r_payload),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_capture && is_mem_access(w_req_type)) w_state_next = ST_ACCESS;
      ST_ACCESS:  if (r_cnt == '0) w_state_next = (r_type == READ_DATA) ? ST_RESPOND : ST_IDLE;
      ST_RESPOND: if (!rsp_busy) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    idle        = (r_state == ST_IDLE);
    rsp_send    = 1'b0;
    rsp_type    = '0;
    rsp_source  = '0;
    rsp_address = '0;
    rsp_payload = '0;
    if (r_state == ST_RESPOND) begin
      rsp_send    = !rsp_busy;
      rsp_type    = READ_RESPONSE;
      rsp_source  = r_source;
      rsp_address = ADDR_W'(RSP_NULL_ADDR);
      rsp_payload = w_rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_type       <= READ_DATA;
      r_source     <= '0;
      r_index      <= '0;
      r_payload    <= '0;
      r_req_accept <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_req_accept <= w_capture;
      if (w_capture) begin
        r_type    <= w_req_type;
        r_source  <= req_source;
        r_index   <= IDX_W'(req_address % ADDR_W'(DEPTH));
        r_payload <= req_payload;
        r_cnt     <= CNT_W'(LATENCY - 1);
        if (!is_mem_access(w_req_type) && (r_err_count != 8'hFF))
          r_err_count <= r_err_count + 8'd1;
      end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign req_accept = r_req_accept;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder: stimulus pushes expected responses
// into a scoreboard that an independent monitor drains on every rsp_send.
module tb_memory_bus_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_type;
  logic [3:0]  req_source;
  logic [31:0] req_address;
  logic [63:0] req_payload;
  logic        req_accept;
  logic        rsp_busy;
  logic        rsp_send;
  logic [1:0]  rsp_type;
  logic [3:0]  rsp_source;
  logic [31:0] rsp_address;
  logic [63:0] rsp_payload;
  logic        idle;
  logic [7:0]  err_count;

  memory_bus_responder #(
    .DEPTH(1024), .LATENCY(LAT), .ADDR_W(32), .DATA_W(64), .ID_W(4)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
    .req_source(req_source), .req_address(req_address), .req_payload(req_payload),
    .req_accept(req_accept), .rsp_busy(rsp_busy), .rsp_send(rsp_send),
    .rsp_type(rsp_type), .rsp_source(rsp_source), .rsp_address(rsp_address),
    .rsp_payload(rsp_payload), .idle(idle), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  src;
    logic [63:0] data;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int issued = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples after the negedge drive has settled.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (req_accept) accepts++;
      if (rsp_send) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=rsp_send src=%0h required=no response (cycle %0d)",
                   rsp_source, cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_type", 64'(rsp_type), 64'd2);
          check("rsp_source", 64'(rsp_source), 64'(e.src));
          check("rsp_address", 64'(rsp_address), 64'd0);
          check("rsp_payload", rsp_payload, e.data);
          if (e.at_cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(e.at_cyc));
          $display("rsp src=%0h payload=%0h cycle=%0d", rsp_source, rsp_payload, cyc);
        end
      end
    end
  end

  // Present a request (caller sits just after a negedge) and wait for its accept.
  task automatic issue(input logic [1:0] t, input logic [3:0] s, input logic [31:0] a,
                       input logic [63:0] d, input bit hold, output int acc_cyc);
    req_type = t; req_source = s; req_address = a; req_payload = d; req_valid = 1'b1;
    issued++;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_accept) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no req_accept required=req_accept type=%0d", t);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (idle) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t, s0, prev;
    logic [31:0] b2b_addr [4];
    logic [63:0] b2b_data [4];
    reset = 1'b1; req_valid = 1'b0; req_type = '0; req_source = '0;
    req_address = '0; req_payload = '0; rsp_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_req_accept", 64'(req_accept), 64'd0);
    check("rst_rsp_send", 64'(rsp_send), 64'd0);
    check("rst_rsp_type", 64'(rsp_type), 64'd0);
    check("rst_rsp_source", 64'(rsp_source), 64'd0);
    check("rst_rsp_address", 64'(rsp_address), 64'd0);
    check("rst_rsp_payload", rsp_payload, 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;

    // Write then read back with exact latency.
    s0 = cyc;
    issue(2'd1, 4'd2, 32'h10, 64'hDEADBEEF, 1'b0, a);
    check("wr_accept_cycle", 64'(a), 64'(s0 + 1));
    wait_idle(t);
    check("wr_idle_cycle", 64'(t), 64'(a + LAT));
    $display("write addr=10 accept=%0d idle=%0d", a, t);
    s0 = cyc;
    issue(2'd0, 4'd5, 32'h10, 64'd0, 1'b0, a);
    check("rd_accept_cycle", 64'(a), 64'(s0 + 1));
    sb.push_back('{4'd5, 64'hDEADBEEF, a + LAT});
    drain();

    // Backpressure: response held while rsp_busy is high.
    rsp_busy = 1'b1;
    issue(2'd0, 4'd7, 32'h10, 64'd0, 1'b0, a);
    sb.push_back('{4'd7, 64'hDEADBEEF, -1});
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      check("busy_no_send", 64'(rsp_send), 64'd0);
      if (cyc >= a + LAT) begin
        check("busy_hold_payload", rsp_payload, 64'hDEADBEEF);
        check("busy_hold_source", 64'(rsp_source), 64'd7);
      end
    end
    rsp_busy = 1'b0;
    @(negedge clk);
    check("busy_release_idle", 64'(idle), 64'd1);
    check("busy_release_sent", 64'(sb.size()), 64'd0);

    // Address wrap at DEPTH.
    issue(2'd1, 4'd1, 32'h405, 64'd7, 1'b0, a);
    wait_idle(t);
    issue(2'd0, 4'd3, 32'h5, 64'd0, 1'b0, a);
    sb.push_back('{4'd3, 64'd7, a + LAT});
    drain();

    // Illegal request types.
    issue(2'd2, 4'd1, 32'h0, 64'd0, 1'b0, a);
    @(negedge clk);
    check("illegal2_err_count", 64'(err_count), 64'd1);
    check("illegal2_idle", 64'(idle), 64'd1);
    issue(2'd3, 4'd1, 32'h0, 64'd0, 1'b0, a);
    @(negedge clk);
    check("illegal3_err_count", 64'(err_count), 64'd2);
    for (int i = 0; i < 298; i++) begin
      issue(2'(2 + (i % 2)), 4'd0, 32'(i), 64'd0, 1'b0, a);
      @(negedge clk);
    end
    check("err_count_saturated", 64'(err_count), 64'd255);
    $display("illegal requests done err_count=%0d", err_count);

    // Reset during a write access discards the write.
    issue(2'd1, 4'd2, 32'h20, 64'd1, 1'b0, a);
    wait_idle(t);
    issue(2'd1, 4'd2, 32'h20, 64'd9, 1'b0, a);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_wr_idle", 64'(idle), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    issue(2'd0, 4'd4, 32'h20, 64'd0, 1'b0, a);
    sb.push_back('{4'd4, 64'd1, a + LAT});
    drain();

    // Reset during a read: no response may follow.
    issue(2'd0, 4'd6, 32'h20, 64'd0, 1'b0, a);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_rd_idle", 64'(idle), 64'd1);
    check("abort_rd_no_send", 64'(rsp_send), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    // Back-to-back reads with the slot refilled right after each accept.
    b2b_addr[0] = 32'h10;  b2b_data[0] = 64'hDEADBEEF;
    b2b_addr[1] = 32'h405; b2b_data[1] = 64'd7;
    b2b_addr[2] = 32'h20;  b2b_data[2] = 64'd1;
    b2b_addr[3] = 32'h5;   b2b_data[3] = 64'd7;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      issue(2'd0, 4'(8 + k), b2b_addr[k], 64'd0, k < 3, a);
      sb.push_back('{4'(8 + k), b2b_data[k], a + LAT});
      if (prev >= 0) check("b2b_accept_spacing", 64'(a - prev), 64'(LAT + 2));
      prev = a;
    end
    drain();

    check("accept_count", 64'(accepts), 64'(issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
